pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/cla_pkg.sv | 10 +
 rtl/cla_group.sv | 31 +++
 rtl/pipelined_cla_adder.sv | 94 +++++++++
 tb/tb_pipelined_cla_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic int unsigned cla_ngroups(input int unsigned width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One 4-bit carry-lookahead group: sum bits, group carry-out and carry into bit 3.
module cla_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a4,
  input  logic [GROUP_W-1:0] b4,
  input  logic               cin,
  output logic [GROUP_W-1:0] s4,
  output logic               cout,
  output logic               c3
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  always_comb begin
    g = a4 & b4;
    p = a4 ^ b4;
    c = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s4 = p ^ c;
    c3 = c[3];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Add/subtract pipelined one 4-bit lookahead group per stage, valid/ready handshake
// with a single global stall driven by the output register.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NGROUPS = cla_ngroups(WIDTH);

  typedef logic [WIDTH-1:0] word_t;

  // *_src: operands/partial sum feeding stage k; *_q: stage k registers.
  logic [NGROUPS-1:0][WIDTH-1:0]   a_src, b_src, s_src, s_d;
  logic [NGROUPS-1:0][WIDTH-1:0]   a_q, b_q, s_q;
  logic [NGROUPS-1:0][GROUP_W-1:0] grp_s;
  logic [NGROUPS-1:0]              c_src, c_d, c_q, c3_w;
  logic [NGROUPS-1:0]              v_d, v_q;
  logic                            ovf_d, ovf_q;
  logic                            stall;

  assign stall    = v_q[NGROUPS-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      // Subtraction is a + ~b + 1; the inverted operand is what gets registered.
      assign a_src[gi] = a;
      assign b_src[gi] = sub ? ~b : b;
      assign c_src[gi] = sub | cin;
      assign s_src[gi] = '0;
      assign v_d[gi]   = in_valid;
    end else begin : g_body
      assign a_src[gi] = a_q[gi-1];
      assign b_src[gi] = b_q[gi-1];
      assign c_src[gi] = c_q[gi-1];
      assign s_src[gi] = s_q[gi-1];
      assign v_d[gi]   = v_q[gi-1];
    end

    cla_group u_group (
      .a4   (a_src[gi][gi*GROUP_W +: GROUP_W]),
      .b4   (b_src[gi][gi*GROUP_W +: GROUP_W]),
      .cin  (c_src[gi]),
      .s4   (grp_s[gi]),
      .cout (c_d[gi]),
      .c3   (c3_w[gi])
    );

    // Insert this group's sum bits into the skew-aligned partial result.
    assign s_d[gi] = (s_src[gi] & ~(word_t'({GROUP_W{1'b1}}) << (gi*GROUP_W)))
                   | (word_t'(grp_s[gi]) << (gi*GROUP_W));
  end

  assign ovf_d = c3_w[NGROUPS-1] ^ c_d[NGROUPS-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      v_q   <= v_d;
      a_q   <= a_src;
      b_q   <= b_src;
      s_q   <= s_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[NGROUPS-1];
  assign sum       = s_q[NGROUPS-1];
  assign cout      = c_q[NGROUPS-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed + randomized scoreboard bench for pipelined_cla_adder at WIDTH=16.
module tb_pipelined_cla_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;
  exp_t sb[$];
  exp_t e;

  logic         hold_pend = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;
  logic         prev_ovf = 1'b0;
  logic [15:0]  pat = '0;
  int           n0;
  int           sent;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb_);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sb_ ? ~y : y;
    full = {1'b0, x} + {1'b0, bb} + (W+1)'(sb_ | ci);
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.v  = (x[W-1] == bb[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  // Monitor: sampled mid-cycle, reflects the transfers the next rising edge performs.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sum", sum, prev_sum);
        chk("hold_cout", cout, prev_cout);
        chk("hold_ovf", ovf, prev_ovf);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_cout", cout, e.c);
          chk("sb_ovf", ovf, e.v);
          n_out++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
      hold_pend = out_valid && !out_ready;
      prev_sum  = sum;
      prev_cout = cout;
      prev_ovf  = ovf;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb_, input logic [W-1:0] es,
                         input logic ec, input logic ev);
    int n;
    a = x; b = y; cin = ci; sub = sb_; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, ev);
    step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    run_one("add_small", 16'h000D, 16'h0007, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b0);
    run_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_one("add_cin",   16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // 8 back-to-back beats, downstream stalls in cycles 6..9.
    n0 = n_out;
    sent = 0;
    for (int i = 0; i < 12; i++) begin
      out_ready = !(i >= 6 && i <= 9);
      in_valid  = (sent < 8);
      a = 16'h1111 * W'(i + 1);
      b = W'($urandom);
      cin = i[0];
      sub = i[1];
      #1;
      chk("stall_in_ready", in_ready, !(i >= 6 && i <= 9));
      if (in_valid && in_ready) sent++;
      @(posedge clock);
      #1;
    end
    drain();
    chk("stall_beats_out", n_out - n0, 8);

    // Alternating bubbles must reappear four cycles later.
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 8) && (i % 2 == 0);
      pat[i]   = in_valid;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'b0;
      sub = 1'b0;
      #1;
      if (i >= 4) chk("bubble_valid", out_valid, pat[i-4]);
      step();
    end
    drain();

    // Reset with three beats in flight.
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("flush_quiet", out_valid, 1'b0);
      step();
    end
    chk("flush_no_results", n_out - n0, 0);
    run_one("post_reset", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Random traffic with random downstream back-pressure.
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
